i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (responder) that answers a single programmable 7-bit address on the same two-wire bus driven by our `i2c_master`. It oversamples SCL/SDA with the system clock, detects START/STOP and bit edges, and shifts bytes in and out. Received write bytes go to the user side as one-cycle valid pulses, and read bytes are requested from the user side one byte ahead. No clock stretching: SCL is input-only.

## Interface
- `DATA_WIDTH`, 8, byte width; only 8 is supported.
- `ADDR_WIDTH`, 7, device address width.
- `SLAVE_ADDR`, 7'h50, address this target acknowledges.
- `i_clk`  in  1  system clock; must be at least 16x the SCL rate.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `scl_in`  in  1  SCL pin value.
- `sda_in`  in  1  SDA pin value.
- `sda_out`  out  1  SDA drive value; constant 0 (open-drain).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `i_tx_data`  in  8  byte returned to the master on reads.
- `o_tx_req`  out  1  one-cycle pulse: present the next read byte on `i_tx_data`.
- `o_rx_data`  out  8  last byte written by the master.
- `o_rx_valid`  out  1  one-cycle pulse; `o_rx_data` is new.
- `o_start`  out  1  one-cycle pulse on every START or repeated START.
- `o_stop`  out  1  one-cycle pulse on STOP.
- `o_busy`  out  1  high from an address-matched START until STOP.

## Operation
- **Input conditioning:** SCL and SDA each pass through a 2-flop synchronizer, then a history flop. Edges and START/STOP are decoded from the synchronized and history values.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rising edge: sample a bit.
  - SCL falling edge: change what this block drives.
- **States:** S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE.
- **From any state:**
  - START: bit counter cleared, pulse `o_start`, go to S_ADDR, `sda_oe`=0.
  - STOP: pulse `o_stop`, go to S_IDLE, `sda_oe`=0, `o_busy`=0.
- **S_ADDR:** shift 8 bits MSB-first on SCL rises (7 address bits plus R/W). On the falling edge after bit 8:
  - Address matches `SLAVE_ADDR`: `sda_oe`=1, `o_busy`=1, go to S_ADDR_ACK. If R/W=1, also pulse `o_tx_req`.
  - No match: go to S_IGNORE.
- **S_ADDR_ACK:** on the next falling edge:
  - R/W=0: `sda_oe`=0, go to S_RX.
  - R/W=1: load `i_tx_data` into the shift register, drive its MSB, go to S_TX.
- **S_RX:** 8 bits sampled on SCL rises. On the falling edge after bit 8:
  - `o_rx_data` ← shift register, pulse `o_rx_valid`.
  - `sda_oe`=1 (every byte is ACKed), go to S_RX_ACK.
- **S_RX_ACK:** on the next falling edge, `sda_oe`=0 and return to S_RX.
- **S_TX:** each falling edge drives the next bit, with `sda_oe` = ~bit. On the falling edge after bit 8, `sda_oe`=0 and go to S_TX_ACK.
- **S_TX_ACK:** sample the master's ACK on the SCL rise.
  - SDA=0 (ACK): pulse `o_tx_req`. On the following falling edge, load `i_tx_data`, drive its MSB, go to S_TX.
  - SDA=1 (NACK): go to S_IGNORE, SDA released.
- **S_IGNORE:** SDA released; leave only on START or STOP.

## Timing
- **Reset values:** every output is 0 (`o_rx_data` = 8'h00, `sda_oe`=0), state is S_IDLE, and the synchronizers are preset to 1. Reset asserted mid-transfer releases SDA in the same cycle, since reset is asynchronous.
- **Detection latency:** a pin change is acted on 3 `i_clk` after it occurs, so `sda_oe` changes 3 cycles after an SCL fall.
- **Pulse timing:** `o_rx_valid`, `o_tx_req`, `o_start` and `o_stop` are exactly 1 cycle wide, registered, and issued in the same cycle as the decoding state transition.
- **Read data deadline:** `i_tx_data` must be stable from `o_tx_req`+1 until the next decoded SCL fall. That window is at least half an SCL period; it is the user's deadline.
- **Precedence:** in the same decode cycle, START/STOP takes priority over a bit edge. SDA changes while SCL is low are data and are never decoded as START/STOP.
- **Counters:** the bit counter is 3 bits plus an 8th-bit flag. It resets on START and after each ACK slot, and never wraps mid-byte.

## Test plan
- **Write, two bytes:** START, addr 0x50 W, 0xA5, 0x3C, STOP.
  - Required: `sda_oe` high during all 3 ACK slots.
  - Required: `o_rx_valid` twice, with `o_rx_data` = 0xA5 then 0x3C.
  - Required: `o_busy` high until `o_stop`.
- **Read, two bytes:** START, addr 0x50 R, `i_tx_data` 0x96 then 0x0F, master ACK then NACK, STOP.
  - Required: the bus shows 0x96 and 0x0F.
  - Required: `o_tx_req` pulses twice (address ACK, first master ACK).
  - Required: SDA is released after the NACK.
- **Address mismatch:** addr 0x51 W followed by one byte.
  - Required: `sda_oe` never asserts.
  - Required: no `o_rx_valid`.
  - Required: `o_busy`=0.
- **Repeated START:** write 0x50 W + 0x11, then repeated START with 0x50 R returning 0x22.
  - Required: `o_start` pulses twice.
  - Required: `o_rx_data`=0x11, and the bus reads 0x22.
- **STOP mid-byte:** STOP after 4 data bits of a write.
  - Required: `o_stop` pulses.
  - Required: no `o_rx_valid`.
  - Required: state returns to S_IDLE; a following write of 0x5A is received correctly.
- **Reset mid-ACK:** pull `i_rst_n` low while `sda_oe`=1.
  - Required: `sda_oe`=0 immediately.
  - Required: all outputs 0; a new transaction after release completes normally.

Source files
------------

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target answering one 7-bit address, oversampled SCL/SDA, no clock stretching.
module i2c_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic                  sda_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic                  o_tx_req,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_start,
  output logic                  o_stop,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            scl_pipe, sda_pipe;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  rw_q, rw_d;
  logic                  oe_d, busy_d, rx_valid_d, tx_req_d, start_d, stop_d;
  logic                  scl_s, scl_h, sda_s, sda_h;
  logic                  scl_rise, scl_fall, start_det, stop_det, addr_hit;

  assign sda_out = 1'b0;

  // pipe[0] is the metastability flop, pipe[1] the synchronized value, pipe[2] its history
  assign scl_s = scl_pipe[1];
  assign scl_h = scl_pipe[2];
  assign sda_s = sda_pipe[1];
  assign sda_h = sda_pipe[2];

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign addr_hit  = (shift_q[DATA_WIDTH-1 -: ADDR_WIDTH] == SLAVE_ADDR);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    rw_d       = rw_q;
    oe_d       = sda_oe;
    busy_d     = o_busy;
    rx_data_d  = o_rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      full_d  = 1'b0;
      oe_d    = 1'b0;
      start_d = 1'b1;
    end else if (stop_det) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      full_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_RX: begin
          if (scl_rise && !full_q) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], sda_s};
            if (cnt_q == 3'd7) full_d = 1'b1;
            else               cnt_d  = cnt_q + 3'd1;
          end else if (scl_fall && full_q) begin
            cnt_d  = 3'd0;
            full_d = 1'b0;
            if (state_q == S_RX) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              oe_d       = 1'b1;
              state_d    = S_RX_ACK;
            end else if (addr_hit) begin
              rw_d     = shift_q[0];
              tx_req_d = shift_q[0];
              oe_d     = 1'b1;
              busy_d   = 1'b1;
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              shift_d = i_tx_data;
              oe_d    = ~i_tx_data[DATA_WIDTH-1];
              state_d = S_TX;
            end else begin
              oe_d    = 1'b0;
              state_d = S_RX;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = S_RX;
          end
        end
        S_TX: begin
          if (scl_rise && !full_q) begin
            if (cnt_q == 3'd7) full_d = 1'b1;
            else               cnt_d  = cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (full_q) begin
              cnt_d   = 3'd0;
              full_d  = 1'b0;
              oe_d    = 1'b0;
              state_d = S_TX_ACK;
            end else begin
              shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
              oe_d    = ~shift_q[DATA_WIDTH-2];
            end
          end
        end
        S_TX_ACK: begin
          // full_q marks that the master's ACK has been seen in this slot
          if (scl_rise && !full_q) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              full_d   = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = S_IGNORE;
            end
          end else if (scl_fall && full_q) begin
            full_d  = 1'b0;
            cnt_d   = 3'd0;
            shift_d = i_tx_data;
            oe_d    = ~i_tx_data[DATA_WIDTH-1];
            state_d = S_TX;
          end
        end
        S_IGNORE: oe_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_pipe   <= 3'b111;
      sda_pipe   <= 3'b111;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= 3'd0;
      full_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe     <= 1'b0;
      o_busy     <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_tx_req   <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
    end else begin
      scl_pipe   <= {scl_pipe[1:0], scl_in};
      sda_pipe   <= {sda_pipe[1:0], sda_in};
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      rw_q       <= rw_d;
      sda_oe     <= oe_d;
      o_busy     <= busy_d;
      o_rx_data  <= rx_data_d;
      o_rx_valid <= rx_valid_d;
      o_tx_req   <= tx_req_d;
      o_start    <= start_d;
      o_stop     <= stop_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench: bus-level master model driving i2c_slave over a wired-AND SDA.
module tb_i2c_slave;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_out, sda_oe, tx_req, rx_valid, start, stop, busy;
  logic [7:0] rx_data;
  logic       sda_line;

  int n_checks = 0;
  int n_fail = 0;
  int txreq_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0, tx_idx = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];

  assign sda_line = m_sda & ~sda_oe;

  i2c_slave dut (
    .i_clk(clk), .i_rst_n(rst_n), .scl_in(m_scl), .sda_in(sda_line),
    .sda_out(sda_out), .sda_oe(sda_oe), .i_tx_data(tx_data), .o_tx_req(tx_req),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_start(start), .o_stop(stop), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_req) begin
      txreq_cnt++;
      if (tx_idx < tx_q.size()) tx_data = tx_q[tx_idx];
      tx_idx++;
    end
    if (start)  start_cnt++;
    if (stop)   stop_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_q;
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_q;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wait_q;
    m_scl = 1'b1; wait_q;
    m_sda = 1'b1; wait_q;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q;
    m_scl = 1'b1; wait_q; wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic read_bit(output logic b, output logic oe);
    m_sda = 1'b1; wait_q;
    m_scl = 1'b1; wait_q;
    b = sda_line;
    oe = sda_oe;
    wait_q;
    m_scl = 1'b0; wait_q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, output logic oe);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack, oe);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b, oe;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b, oe);
      d = {d[6:0], b};
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_checks++; if (sda_out !== 1'b0)   begin n_fail++; $display("FAIL reset_sda_out: got %b want 0", sda_out); end
    n_checks++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if ({rx_valid, tx_req, start, stop, busy} !== 5'b0)
      begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", {rx_valid, tx_req, start, stop, busy}); end
    rst_n = 1'b1;
    wait_q;
  endtask

  task automatic test_write;
    logic a0, a1, a2, o0, o1, o2;
    int rx0 = rx_log.size(), st0 = start_cnt, sp0 = stop_cnt;
    i2c_start;
    write_byte(8'hA0, a0, o0);
    write_byte(8'hA5, a1, o1);
    write_byte(8'h3C, a2, o2);
    n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
    n_checks++; if ({o0, o1, o2} !== 3'b111) begin n_fail++; $display("FAIL write_oe_in_ack: got %b want 111", {o0, o1, o2}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_before_stop: got %b want 1", busy); end
    i2c_stop;
    wait_q;
    n_checks++; if (rx_log.size() - rx0 != 2) begin n_fail++; $display("FAIL write_rx_count: got %0d want 2", rx_log.size() - rx0); end
    else begin
      n_checks++; if (rx_log[rx0] !== 8'hA5)   begin n_fail++; $display("FAIL write_rx0: got %h want a5", rx_log[rx0]); end
      n_checks++; if (rx_log[rx0+1] !== 8'h3C) begin n_fail++; $display("FAIL write_rx1: got %h want 3c", rx_log[rx0+1]); end
    end
    n_checks++; if (start_cnt - st0 != 1) begin n_fail++; $display("FAIL write_start_count: got %0d want 1", start_cnt - st0); end
    n_checks++; if (stop_cnt - sp0 != 1)  begin n_fail++; $display("FAIL write_stop_count: got %0d want 1", stop_cnt - sp0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read;
    logic a, o;
    logic [7:0] d0, d1;
    int tr0 = txreq_cnt;
    tx_q.push_back(8'h96);
    tx_q.push_back(8'h0F);
    i2c_start;
    write_byte(8'hA1, a, o);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", a); end
    read_byte(d0);
    write_bit(1'b0);
    read_byte(d1);
    write_bit(1'b1);
    n_checks++; if (d0 !== 8'h96) begin n_fail++; $display("FAIL read_byte0: got %h want 96", d0); end
    n_checks++; if (d1 !== 8'h0F) begin n_fail++; $display("FAIL read_byte1: got %h want 0f", d1); end
    n_checks++; if (txreq_cnt - tr0 != 2) begin n_fail++; $display("FAIL read_tx_req_count: got %0d want 2", txreq_cnt - tr0); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    i2c_stop;
    wait_q;
  endtask

  task automatic test_mismatch;
    logic a0, a1, o0, o1;
    int rx0 = rx_log.size(), oe0 = oe_cnt;
    i2c_start;
    write_byte(8'hA2, a0, o0);
    write_byte(8'h12, a1, o1);
    n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL mismatch_nack: got %b want 11", {a0, a1}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b want 0", busy); end
    i2c_stop;
    wait_q;
    n_checks++; if (oe_cnt != oe0) begin n_fail++; $display("FAIL mismatch_oe_cycles: got %0d want 0", oe_cnt - oe0); end
    n_checks++; if (rx_log.size() != rx0) begin n_fail++; $display("FAIL mismatch_rx_count: got %0d want 0", rx_log.size() - rx0); end
  endtask

  task automatic test_repeated_start;
    logic a0, a1, a2, o;
    logic [7:0] d;
    int st0 = start_cnt;
    tx_q.push_back(8'h22);
    i2c_start;
    write_byte(8'hA0, a0, o);
    write_byte(8'h11, a1, o);
    i2c_start;
    write_byte(8'hA1, a2, o);
    read_byte(d);
    write_bit(1'b1);
    i2c_stop;
    wait_q;
    n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); end
    n_checks++; if (start_cnt - st0 != 2) begin n_fail++; $display("FAIL rs_start_count: got %0d want 2", start_cnt - st0); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data: got %h want 11", rx_data); end
    n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL rs_read_byte: got %h want 22", d); end
  endtask

  task automatic test_stop_mid_byte;
    logic a, o;
    int rx0 = rx_log.size(), sp0 = stop_cnt;
    i2c_start;
    write_byte(8'hA0, a, o);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop;
    wait_q;
    n_checks++; if (stop_cnt - sp0 != 1) begin n_fail++; $display("FAIL midstop_stop_count: got %0d want 1", stop_cnt - sp0); end
    n_checks++; if (rx_log.size() != rx0) begin n_fail++; $display("FAIL midstop_rx_count: got %0d want 0", rx_log.size() - rx0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midstop_busy: got %b want 0", busy); end
    i2c_start;
    write_byte(8'hA0, a, o);
    write_byte(8'h5A, a, o);
    i2c_stop;
    wait_q;
    n_checks++; if (rx_log.size() - rx0 != 1) begin n_fail++; $display("FAIL midstop_followup_count: got %0d want 1", rx_log.size() - rx0); end
    else begin
      n_checks++; if (rx_log[rx0] !== 8'h5A) begin n_fail++; $display("FAIL midstop_followup_data: got %h want 5a", rx_log[rx0]); end
    end
  endtask

  task automatic test_reset_mid_ack;
    logic [7:0] addr = 8'hA0;
    logic a0, a1, o;
    int rx0;
    i2c_start;
    for (int i = 7; i >= 0; i--) write_bit(addr[i]);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstack_pre_oe: got %b want 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstack_oe_immediate: got %b want 0", sda_oe); end
    n_checks++; if ({busy, rx_valid, tx_req, start, stop} !== 5'b0)
      begin n_fail++; $display("FAIL rstack_outputs: got %b want 00000", {busy, rx_valid, tx_req, start, stop}); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstack_rx_data: got %h want 00", rx_data); end
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_q;
    rst_n = 1'b1;
    wait_q;
    rx0 = rx_log.size();
    i2c_start;
    write_byte(8'hA0, a0, o);
    write_byte(8'h77, a1, o);
    i2c_stop;
    wait_q;
    n_checks++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL rstack_new_acks: got %b want 00", {a0, a1}); end
    n_checks++; if (rx_log.size() - rx0 != 1) begin n_fail++; $display("FAIL rstack_new_count: got %0d want 1", rx_log.size() - rx0); end
    else begin
      n_checks++; if (rx_log[rx0] !== 8'h77) begin n_fail++; $display("FAIL rstack_new_data: got %h want 77", rx_log[rx0]); end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_repeated_start;
    test_stop_mid_byte;
    test_reset_mid_ack;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
